// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop sync, mid-bit sampling,
// one-entry valid/ready output register and framing/overrun pulses.
//
// Ports:
//   clk       system clock, rising edge
//   res       synchronous active-high reset
//   rx        serial line, idle high, asynchronous
//   data      received byte, meaningful while valid=1
//   valid     byte held in output register
//   ready     consumer accepts byte on valid&ready
//   frame_err one-cycle pulse, stop bit sampled low
//   overrun   one-cycle pulse, byte dropped because register full
//   busy      frame reception in progress
module uart_rx #(
  parameter int CLK       = 16,
  parameter int BAUD_RATE = 1000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam longint DIVL =
    (longint'(CLK) * 64'd1000000) / longint'(BAUD_RATE);
  localparam int DIV  = int'(DIVL);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  if (DIV < 4) begin : g_div_chk
    $error("uart_rx: DIV must be at least 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shift;
  logic          tick_h, tick_b;
  logic          stop_ok, stop_bad;
  logic          deliver, drop, take;

  // Sync flops preset to the idle level so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (res) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick_h = (cnt == CW'(HALF - 1));
  assign tick_b = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (res) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (!rx_s) state_n = S_START;
      S_START: if (tick_h) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick_b && bitn == 3'd7) state_n = S_STOP;
      S_STOP:  if (tick_b) state_n = rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
    end else begin
      unique case (state)
        S_START: begin
          cnt <= tick_h ? '0 : cnt + CW'(1);
          if (tick_h) bitn <= '0;
        end
        S_DATA: begin
          cnt <= tick_b ? '0 : cnt + CW'(1);
          if (tick_b) begin
            shift <= {rx_s, shift[7:1]};
            bitn  <= bitn + 3'd1;
          end
        end
        S_STOP:  cnt <= tick_b ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    stop_ok  = (state == S_STOP) && tick_b && rx_s;
    stop_bad = (state == S_STOP) && tick_b && !rx_s;
    take     = valid && ready;
    // A byte may land in the same cycle the old one is being drained.
    deliver  = stop_ok && (!valid || ready);
    drop     = stop_ok && valid && !ready;
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= drop;
      if (deliver) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (take) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
